// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundle of requester handshake, UART transmit-FIFO write port
//                and arbiter status signals shared by uart_tx_arbiter.
//                master = requesters/FIFO side, slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) ();
    localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side: one valid/last bit and one byte lane per requester
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ack;

    // UART transmit FIFO write port
    logic [DATA_WIDTH-1:0]         fifo_wdata;
    logic                          fifo_wr_en;
    logic                          fifo_full;

    // Arbiter status
    logic [NUM_REQ-1:0]            grant;
    logic [c_id_w-1:0]             owner_id;
    logic                          busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ack, fifo_wdata, fifo_wr_en, grant, owner_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ack, fifo_wdata, fifo_wr_en, grant, owner_id, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmit FIFO write
//                port among NUM_REQ packet streams. A grant is held for a
//                whole packet but released after MAX_BURST accepted bytes so
//                one requester cannot starve the others.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_id_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_scan_w = c_id_w + 1;
    localparam int c_cnt_w  = $clog2(MAX_BURST + 1);

    localparam logic [c_id_w-1:0]   c_last_id  = c_id_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_cap  = c_cnt_w'(MAX_BURST - 1);
    localparam logic [c_scan_w-1:0] c_scan_num = c_scan_w'(NUM_REQ);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_xfer = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [c_id_w-1:0]  owner_q,  owner_d;
    logic [c_id_w-1:0]  rr_ptr_q, rr_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];
    logic                  w_busy;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic                  w_accept;
    logic                  w_cap_hit;
    logic                  w_burst_end;
    logic [c_id_w-1:0]     w_owner_next;
    logic                  w_arb_found;
    logic [c_id_w-1:0]     w_arb_idx;
    logic [c_scan_w-1:0]   w_scan;

    // Split the flattened data bus into one byte lane per requester
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_req_bytes[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_busy        = (state_q == c_st_xfer);
    assign w_owner_valid = bus.req_valid[owner_q];
    assign w_owner_last  = bus.req_last[owner_q];

    // A byte moves only from the owner, only while busy, only if the FIFO has room
    assign w_accept      = w_busy & w_owner_valid & ~bus.fifo_full;

    // The burst cap fires on the MAX_BURST-th accepted byte of this grant
    assign w_cap_hit     = (count_q == c_cnt_cap);
    assign w_burst_end   = w_accept & (w_owner_last | w_cap_hit);

    // Pointer moves to the requester after the one just served, wrapping
    assign w_owner_next  = (owner_q == c_last_id) ? '0 : owner_q + c_id_w'(1);

    // Pick the first valid requester scanning upward from the rr pointer
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, rr_ptr_q} + c_scan_w'(i);
            if (w_scan >= c_scan_num) begin
                w_scan = w_scan - c_scan_num;
            end
            if (!w_arb_found && bus.req_valid[w_scan[c_id_w-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan[c_id_w-1:0];
            end
        end
    end

    // Next-state logic: grant on any request in IDLE, release on last byte or cap
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        case (state_q)
            c_st_idle: begin
                if (w_arb_found) begin
                    state_d = c_st_xfer;
                    grant_d = NUM_REQ'(1) << w_arb_idx;
                    owner_d = w_arb_idx;
                    count_d = '0;
                end
            end
            c_st_xfer: begin
                // Stalls (owner not valid, FIFO full) leave everything frozen
                if (w_accept) begin
                    count_d = count_q + c_cnt_w'(1);
                    if (w_burst_end) begin
                        state_d  = c_st_idle;
                        grant_d  = '0;
                        rr_ptr_d = w_owner_next;
                        count_d  = '0;
                    end
                end
            end
            default: begin
                state_d = c_st_idle;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= c_st_idle;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: ack/write/data are combinational from the registered owner, so
    // they drop in the same cycle reset asserts.
    // ------------------------------------------------------------------------
    assign bus.req_ack    = w_accept ? grant_q : '0;
    assign bus.fifo_wr_en = w_accept;
    assign bus.fifo_wdata = w_busy ? w_req_bytes[owner_q] : '0;
    assign bus.grant      = grant_q;
    assign bus.owner_id   = owner_q;
    assign bus.busy       = w_busy;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(grant_q));

    a_busy_has_grant: assert property (@(posedge clk) disable iff (!reset_n)
        w_busy == (|grant_q));

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        w_accept |-> !bus.fifo_full);

    a_count_below_cap: assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= c_cnt_cap);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter with
//                NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every arbiter output against hand-computed values
    task automatic expect_out(input string tag, input logic [3:0] g, input logic b,
                              input logic we, input logic [7:0] wd, input logic [3:0] ack);
        chk({tag, "/grant"}, 32'(bus.grant), 32'(g));
        chk({tag, "/busy"},  32'(bus.busy), 32'(b));
        chk({tag, "/wr_en"}, 32'(bus.fifo_wr_en), 32'(we));
        chk({tag, "/wdata"}, 32'(bus.fifo_wdata), 32'(wd));
        chk({tag, "/ack"},   32'(bus.req_ack), 32'(ack));
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[i]       = v;
        bus.req_data[i*8 +: 8] = d;
        bus.req_last[i]        = l;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        set_req(1, 1'b1, 8'h11, 1'b0);
        #1;
        expect_out("reset", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        chk("reset/owner", 32'(bus.owner_id), 32'd0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        step();
        reset_n = 1'b1;

        // ---------------- contention: req0 and req2, pointer 0 ----------------
        step();
        set_req(0, 1'b1, 8'hA0, 1'b0);
        set_req(2, 1'b1, 8'hC0, 1'b0);
        #1; expect_out("cont_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("cont_r0b0", 4'b0001, 1'b1, 1'b1, 8'hA0, 4'b0001);
        chk("cont_r0b0/owner", 32'(bus.owner_id), 32'd0);
        step(); set_req(0, 1'b1, 8'hA1, 1'b1);
        #1; expect_out("cont_r0b1", 4'b0001, 1'b1, 1'b1, 8'hA1, 4'b0001);
        step(); set_req(0, 1'b0, 8'h00, 1'b0);
        #1; expect_out("cont_gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("cont_r2b0", 4'b0100, 1'b1, 1'b1, 8'hC0, 4'b0100);
        chk("cont_r2b0/owner", 32'(bus.owner_id), 32'd2);
        step(); set_req(2, 1'b1, 8'hC1, 1'b1);
        #1; expect_out("cont_r2b1", 4'b0100, 1'b1, 1'b1, 8'hC1, 4'b0100);
        // pointer is now 3: req3 wins over req0, then req0 via wrap
        step();
        set_req(2, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'hD0, 1'b1);
        set_req(3, 1'b1, 8'hE0, 1'b1);
        #1; expect_out("cont_gap2", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("cont_r3", 4'b1000, 1'b1, 1'b1, 8'hE0, 4'b1000);
        chk("cont_r3/owner", 32'(bus.owner_id), 32'd3);
        step(); set_req(3, 1'b0, 8'h00, 1'b0);
        #1; expect_out("cont_gap3", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("cont_r0wrap", 4'b0001, 1'b1, 1'b1, 8'hD0, 4'b0001);
        step(); set_req(0, 1'b0, 8'h00, 1'b0);
        #1; expect_out("cont_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // ---------------- single requester 1: 41 42 43, pointer 1 ----------------
        step(); set_req(1, 1'b1, 8'h41, 1'b0);
        #1; expect_out("s_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("s_b0", 4'b0010, 1'b1, 1'b1, 8'h41, 4'b0010);
        step(); set_req(1, 1'b1, 8'h42, 1'b0);
        #1; expect_out("s_b1", 4'b0010, 1'b1, 1'b1, 8'h42, 4'b0010);
        step(); set_req(1, 1'b1, 8'h43, 1'b1);
        #1; expect_out("s_b2", 4'b0010, 1'b1, 1'b1, 8'h43, 4'b0010);
        // pointer must be 2: of req1 and req3, req3 is served first
        step();
        set_req(1, 1'b1, 8'h44, 1'b1);
        set_req(3, 1'b1, 8'h46, 1'b1);
        #1; expect_out("s_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("ptr2_r3", 4'b1000, 1'b1, 1'b1, 8'h46, 4'b1000);
        step(); set_req(3, 1'b0, 8'h00, 1'b0);
        #1; expect_out("ptr2_gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("ptr2_r1", 4'b0010, 1'b1, 1'b1, 8'h44, 4'b0010);
        step(); set_req(1, 1'b0, 8'h00, 1'b0);
        #1; expect_out("ptr2_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // ---------------- backpressure: req2 50..53, pointer 2 ----------------
        step(); set_req(2, 1'b1, 8'h50, 1'b0);
        #1; expect_out("bp_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("bp_b0", 4'b0100, 1'b1, 1'b1, 8'h50, 4'b0100);
        step();
        set_req(2, 1'b1, 8'h51, 1'b0);
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1; expect_out("bp_stall", 4'b0100, 1'b1, 1'b0, 8'h51, 4'b0000);
            step();
        end
        bus.fifo_full = 1'b0;
        #1; expect_out("bp_b1", 4'b0100, 1'b1, 1'b1, 8'h51, 4'b0100);
        step(); set_req(2, 1'b1, 8'h52, 1'b0);
        #1; expect_out("bp_b2", 4'b0100, 1'b1, 1'b1, 8'h52, 4'b0100);
        step(); set_req(2, 1'b1, 8'h53, 1'b1);
        #1; expect_out("bp_b3", 4'b0100, 1'b1, 1'b1, 8'h53, 4'b0100);
        step(); set_req(2, 1'b0, 8'h00, 1'b0);
        #1; expect_out("bp_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // ---------------- burst cap: req1 60..65 vs req2 70,71, pointer 3 ----------------
        step();
        set_req(1, 1'b1, 8'h60, 1'b0);
        set_req(2, 1'b1, 8'h70, 1'b0);
        #1; expect_out("mb_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("mb_b0", 4'b0010, 1'b1, 1'b1, 8'h60, 4'b0010);
        step(); set_req(1, 1'b1, 8'h61, 1'b0);
        #1; expect_out("mb_b1", 4'b0010, 1'b1, 1'b1, 8'h61, 4'b0010);
        step(); set_req(1, 1'b1, 8'h62, 1'b0);
        #1; expect_out("mb_b2", 4'b0010, 1'b1, 1'b1, 8'h62, 4'b0010);
        step(); set_req(1, 1'b1, 8'h63, 1'b0);
        #1; expect_out("mb_b3", 4'b0010, 1'b1, 1'b1, 8'h63, 4'b0010);
        step(); set_req(1, 1'b1, 8'h64, 1'b0);
        #1; expect_out("mb_release", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("mb_r2b0", 4'b0100, 1'b1, 1'b1, 8'h70, 4'b0100);
        step(); set_req(2, 1'b1, 8'h71, 1'b1);
        #1; expect_out("mb_r2b1", 4'b0100, 1'b1, 1'b1, 8'h71, 4'b0100);
        step(); set_req(2, 1'b0, 8'h00, 1'b0);
        #1; expect_out("mb_gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("mb_r1b4", 4'b0010, 1'b1, 1'b1, 8'h64, 4'b0010);
        step(); set_req(1, 1'b1, 8'h65, 1'b1);
        #1; expect_out("mb_r1b5", 4'b0010, 1'b1, 1'b1, 8'h65, 4'b0010);
        step(); set_req(1, 1'b0, 8'h00, 1'b0);
        #1; expect_out("mb_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // ---------------- valid drop: req3 80..82, req0 waiting, pointer 2 ----------------
        step();
        set_req(3, 1'b1, 8'h80, 1'b0);
        set_req(0, 1'b1, 8'h90, 1'b1);
        #1; expect_out("vd_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("vd_b0", 4'b1000, 1'b1, 1'b1, 8'h80, 4'b1000);
        step();
        set_req(3, 1'b0, 8'h81, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1; expect_out("vd_hold", 4'b1000, 1'b1, 1'b0, 8'h81, 4'b0000);
            step();
        end
        set_req(3, 1'b1, 8'h81, 1'b0);
        #1; expect_out("vd_b1", 4'b1000, 1'b1, 1'b1, 8'h81, 4'b1000);
        step(); set_req(3, 1'b1, 8'h82, 1'b1);
        #1; expect_out("vd_b2", 4'b1000, 1'b1, 1'b1, 8'h82, 4'b1000);
        step(); set_req(3, 1'b0, 8'h00, 1'b0);
        #1; expect_out("vd_gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("vd_r0", 4'b0001, 1'b1, 1'b1, 8'h90, 4'b0001);
        step(); set_req(0, 1'b0, 8'h00, 1'b0);
        #1; expect_out("vd_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        // ---------------- reset mid-burst: req2 5-byte packet, pointer 1 ----------------
        step(); set_req(2, 1'b1, 8'hB0, 1'b0);
        #1; expect_out("rm_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("rm_b0", 4'b0100, 1'b1, 1'b1, 8'hB0, 4'b0100);
        step(); set_req(2, 1'b1, 8'hB1, 1'b0);
        #1; expect_out("rm_b1", 4'b0100, 1'b1, 1'b1, 8'hB1, 4'b0100);
        step();
        set_req(2, 1'b1, 8'hB2, 1'b0);
        reset_n = 1'b0;
        #1; expect_out("rm_reset", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        chk("rm_reset/owner", 32'(bus.owner_id), 32'd0);
        step(); set_req(2, 1'b0, 8'h00, 1'b0);
        #1; expect_out("rm_hold", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        // pointer back to 0: req0 beats req3
        step();
        reset_n = 1'b1;
        set_req(0, 1'b1, 8'hF0, 1'b1);
        set_req(3, 1'b1, 8'hF3, 1'b1);
        #1; expect_out("rm_post_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("rm_r0", 4'b0001, 1'b1, 1'b1, 8'hF0, 4'b0001);
        step(); set_req(0, 1'b0, 8'h00, 1'b0);
        #1; expect_out("rm_gap", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
        step();
        #1; expect_out("rm_r3", 4'b1000, 1'b1, 1'b1, 8'hF3, 4'b1000);
        step(); set_req(3, 1'b0, 8'h00, 1'b0);
        #1; expect_out("rm_end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmit path among several requesters. It writes into the transmit FIFO write port (w_data / wr_en / T_full) of the UART top level. Each requester streams a packet of bytes using a valid/ack handshake. A grant is held for the whole packet, capped at MaxBurst bytes so one requester cannot starve the others.

Parameters:
NumReq, 4, number of requesters (2..8)
DataWidth, 8, byte width; matches the UART transmit data width
MaxBurst, 16, max bytes written per grant before forced release (1..256)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NumReq  per-requester byte available
req_data  input  NumReq*DataWidth  flattened bytes; requester i at bits [i*DataWidth +: DataWidth]
req_last  input  NumReq  current byte is the final byte of the packet
req_ack  output  NumReq  byte accepted this cycle (one-hot or zero)
fifo_wdata  output  DataWidth  to UART w_data
fifo_wr_en  output  1  to UART wr_en
fifo_full  input  1  from UART T_full
grant  output  NumReq  registered one-hot current owner; zero when idle
owner_id  output  clog2(NumReq)  index of owner; valid only when busy
busy  output  1  burst in progress (state XFER)

Behaviour:
- Reset (async, reset_n=0): state IDLE, grant=0, owner_id=0, rr pointer=0, beat count=0, busy=0. Combinational outputs req_ack=0, fifo_wr_en=0, fifo_wdata=0.
- State IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise pick the first requester with req_valid=1, scanning from the rr pointer upward with wrap from NumReq-1 to 0.
  - Register grant/owner_id, clear count, go to XFER. Grant is visible the next cycle.
- State XFER, owner g:
  - accept = req_valid[g] & ~fifo_full.
  - req_ack[g] = accept; fifo_wr_en = accept; fifo_wdata = req_data[g] while busy, 0 otherwise. All three are combinational from registered grant and the inputs.
  - Each accepted byte increments count.
  - Burst ends on an accepted byte where req_last[g]=1, or where count == MaxBurst-1.
  - On burst end, next cycle: state IDLE, grant=0, busy=0, rr pointer=(g+1) mod NumReq.
  - If req_valid[g] drops mid-packet, grant is held and nothing is written; there is no timeout.
  - fifo_full=1 stalls the burst: no ack, no write, count unchanged.
- Latency:
  - req_valid rising in IDLE at cycle t gives grant at t+1. The first write happens at t+1 if fifo_full=0.
  - Back-to-back bursts always have one IDLE cycle between them.
  - A packet of L bytes with no backpressure occupies L cycles in XFER.
- Arbitration:
  - Only the owner is acked. Other requesters hold valid and data stable until acked; the bench checks this as an assumption.
  - req_valid changes of non-owners have no effect during XFER.
- Forced release at MaxBurst:
  - The requester keeps its remaining bytes and re-arbitrates.
  - Its packet continues in a later grant.
  - The rr pointer has advanced, so any other pending requester is served first.
- count width: clog2(MaxBurst+1). It never exceeds MaxBurst-1 at the compare point.
- The rr pointer updates only on burst end, never in IDLE.
- Reset mid-burst:
  - Everything returns to reset values immediately; fifo_wr_en drops in the same cycle reset asserts.
  - Partially sent packets are not resumed.
- Invariants:
  - grant is one-hot or zero.
  - fifo_wr_en implies ~fifo_full.
  - fifo_wr_en == |req_ack.

Test Plan:
- Single requester: req 1 sends 0x41,0x42,0x43 (last on 0x43), fifo_full=0. Expect grant=0010 one cycle after valid, three consecutive fifo_wr_en with those bytes, then busy=0 and rr pointer=2.
- Contention: requesters 0 and 2 both valid from reset, each sending a 2-byte packet. Expect order: req 0 both bytes, one IDLE cycle, req 2 both bytes. Then re-raise req 0 and req 3: req 3 is served first (pointer=3), then req 0 via wrap.
- Backpressure: fifo_full held high for 5 cycles mid-packet. Expect no req_ack and no fifo_wr_en during those cycles, grant held, count frozen, bytes resume in order after release.
- MaxBurst=4, req 1 sends 6 bytes while req 2 is waiting. Expect 4 writes from req 1, release, 1 IDLE cycle, req 2's full packet, then req 1's remaining 2 bytes.
- Valid drop: owner deasserts req_valid for 3 cycles without last. Expect grant held, no writes, and other requesters not acked.
- Reset mid-burst: assert reset_n=0 after the 2nd byte of 5. Expect grant, busy, fifo_wr_en and req_ack at 0 immediately. After release, a new request from req 0 is granted first (pointer=0).
